led_sequencer: RTL and testbench

//  Parametrised multi-channel dynamic LED colour sequencer; next generation of the single-channel lights block.

---
 rtl/led_seq_pkg.sv | 27 ++
 rtl/led_sequencer_if.sv | 39 +++
 rtl/led_seq_channel.sv | 92 +++++++++
 rtl/led_sequencer.sv | 113 +++++++++++
 tb/tb_led_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg
// Shared definitions for the multi-channel LED colour sequencer:
//   - direction encoding (DIR_UP / DIR_DOWN) of the per-channel dir input
//   - mode encoding (MODE_LEVEL / MODE_EDGE) of the per-channel edge_mode input
//   - colour_in_range(): inclusive range check used by the channel step logic
//     and by the load decode in the top level
// ---------------------------------------------------------------------------
package led_seq_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } mode_e;

    // Inclusive range check on integer-extended colour codes, so callers with
    // any colour width can share it.
    function automatic logic colour_in_range(input int code, input int lo, input int hi);
        return (code >= lo) && (code <= hi);
    endfunction

endpackage

// File: rtl/led_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_sequencer_if
// Direct colour load bus of the LED sequencer.
// Signals:
//   load_valid   load request, sampled on a single clock edge
//   load_ch      target channel of the load
//   load_colour  colour code to load
//   load_err     one-cycle pulse when a load is rejected
// Modports:
//   master  - drives the load request, observes load_err (board controller/bench)
//   slave   - receives the load request, drives load_err (led_sequencer)
// ---------------------------------------------------------------------------
interface led_sequencer_if #(
    parameter int CHANNELS = 4,
    parameter int COLOUR_W = 3
);
    // A single channel still needs a one-bit channel select.
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                load_valid;
    logic [CH_W-1:0]     load_ch;
    logic [COLOUR_W-1:0] load_colour;
    logic                load_err;

    modport master (
        output load_valid,
        output load_ch,
        output load_colour,
        input  load_err
    );

    modport slave (
        input  load_valid,
        input  load_ch,
        input  load_colour,
        output load_err
    );

endinterface

// File: rtl/led_seq_channel.sv
// ---------------------------------------------------------------------------
// led_seq_channel
// One LED channel: colour register, button history, step and wrap logic.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous, active-low reset
//   button       advance request
//   dir          0 = step up, 1 = step down
//   edge_mode    0 = step every cycle button is high, 1 = step on rising edge
//   auto_step    extra step request from the shared auto-advance prescaler
//   load_en      accepted load targeting this channel (already range checked)
//   load_colour  colour to take when load_en is high
//   colour       registered colour code
//   wrap         one-cycle pulse when the colour wraps at a range end
// ---------------------------------------------------------------------------
module led_seq_channel
    import led_seq_pkg::*;
#(
    parameter int COLOUR_W   = 3,
    parameter int MIN_COLOUR = 1,
    parameter int MAX_COLOUR = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                button,
    input  logic                dir,
    input  logic                edge_mode,
    input  logic                auto_step,
    input  logic                load_en,
    input  logic [COLOUR_W-1:0] load_colour,
    output logic [COLOUR_W-1:0] colour,
    output logic                wrap
);

    localparam logic [COLOUR_W-1:0] MIN_C = COLOUR_W'(MIN_COLOUR);
    localparam logic [COLOUR_W-1:0] MAX_C = COLOUR_W'(MAX_COLOUR);

    logic                button_q;
    logic                step;
    logic [COLOUR_W-1:0] colour_next;
    logic                wrap_next;

    // Button and auto requests are OR-ed, so a channel never steps twice in
    // one cycle.
    assign step = ((mode_e'(edge_mode) == MODE_EDGE) ? (button & ~button_q) : button)
                  | auto_step;

    // Next colour: a load overrides any step; out-of-range colours snap to
    // the range end the step is heading away from, without a wrap pulse.
    always_comb begin
        colour_next = colour;
        wrap_next   = 1'b0;
        if (load_en) begin
            colour_next = load_colour;
        end else if (step) begin
            if (dir_e'(dir) == DIR_UP) begin
                if (colour == MAX_C) begin
                    colour_next = MIN_C;
                    wrap_next   = 1'b1;
                end else if (!colour_in_range(int'(colour), MIN_COLOUR, MAX_COLOUR)) begin
                    colour_next = MIN_C;
                end else begin
                    colour_next = colour + COLOUR_W'(1);
                end
            end else begin
                if (colour == MIN_C) begin
                    colour_next = MAX_C;
                    wrap_next   = 1'b1;
                end else if (!colour_in_range(int'(colour), MIN_COLOUR, MAX_COLOUR)) begin
                    colour_next = MAX_C;
                end else begin
                    colour_next = colour - COLOUR_W'(1);
                end
            end
        end
    end

    // Button history tracks the raw button every cycle, whatever the mode,
    // so switching into edge mode with the button held does not step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            colour   <= MIN_C;
            wrap     <= 1'b0;
            button_q <= 1'b0;
        end else begin
            colour   <= colour_next;
            wrap     <= wrap_next;
            button_q <= button;
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
// Multi-channel LED colour sequencer. Each channel steps its colour code
// through [MIN_COLOUR..MAX_COLOUR] on button activity; colours can also be
// loaded directly over the load bus.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   button     per-channel advance request
//   dir        per-channel direction (0 = up, 1 = down)
//   edge_mode  per-channel mode (0 = level, 1 = rising edge)
//   auto_en    per-channel auto-advance enable
//   load_bus   load request (valid/channel/colour) and load_err pulse
//   colour     colour codes, channel i at [i*COLOUR_W +: COLOUR_W]
//   wrap       per-channel one-cycle wrap pulse
// Configuration macro:
//   AUTO_ADVANCE_EN - adds a free-running prescaler; every PRESCALE cycles
//                     each channel with auto_en set takes one step.
//                     Without it auto_en and PRESCALE have no effect.
// ---------------------------------------------------------------------------
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int COLOUR_W   = 3,
    parameter int MIN_COLOUR = 1,
    parameter int MAX_COLOUR = 6,
    parameter int PRESCALE   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          button,
    input  logic [CHANNELS-1:0]          dir,
    input  logic [CHANNELS-1:0]          edge_mode,
    input  logic [CHANNELS-1:0]          auto_en,
    led_sequencer_if.slave               load_bus,
    output logic [CHANNELS*COLOUR_W-1:0] colour,
    output logic [CHANNELS-1:0]          wrap
);

    logic                load_accept;
    logic                load_err_q;
    logic [CHANNELS-1:0] auto_step;

    // A load is only accepted for an existing channel and a legal colour;
    // anything else just raises load_err.
    assign load_accept = load_bus.load_valid
                         && (int'(load_bus.load_ch) < CHANNELS)
                         && colour_in_range(int'(load_bus.load_colour), MIN_COLOUR, MAX_COLOUR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_bus.load_valid & ~load_accept;
        end
    end

    assign load_bus.load_err = load_err_q;

`ifdef AUTO_ADVANCE_EN
    localparam int PS_W = $clog2(PRESCALE);

    logic [PS_W-1:0] prescale_cnt;
    logic            tick;

    assign tick      = (prescale_cnt == PS_W'(PRESCALE - 1));
    assign auto_step = auto_en & {CHANNELS{tick}};

    // Free-running count 0..PRESCALE-1; the tick lands on the last count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_cnt <= '0;
        end else if (tick) begin
            prescale_cnt <= '0;
        end else begin
            prescale_cnt <= prescale_cnt + PS_W'(1);
        end
    end
`else
    // No auto-advance hardware: auto_en and PRESCALE are deliberately sunk.
    logic [CHANNELS-1:0] unused_auto_en;
    logic [31:0]         unused_prescale;

    assign unused_auto_en  = auto_en;
    assign unused_prescale = PRESCALE;
    assign auto_step       = '0;
`endif

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        logic load_en;

        assign load_en = load_accept && (int'(load_bus.load_ch) == i);

        led_seq_channel #(
            .COLOUR_W   (COLOUR_W),
            .MIN_COLOUR (MIN_COLOUR),
            .MAX_COLOUR (MAX_COLOUR)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .button      (button[i]),
            .dir         (dir[i]),
            .edge_mode   (edge_mode[i]),
            .auto_step   (auto_step[i]),
            .load_en     (load_en),
            .load_colour (load_bus.load_colour),
            .colour      (colour[i*COLOUR_W +: COLOUR_W]),
            .wrap        (wrap[i])
        );
    end

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
// Self-checking bench for led_sequencer with 4 channels, colours 1..6 and
// PRESCALE = 4. A table of per-cycle vectors covers stepping, wrapping, edge
// mode and loads; hand-written sequences cover mid-run reset, the edge-mode
// switch with the button held, and auto-advance (AUTO_ADVANCE_EN).
// ---------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int CHANNELS = 4;
    localparam int COLOUR_W = 3;

    typedef struct {
        string      name;
        logic [3:0] button;
        logic [3:0] dir;
        logic [3:0] edge_mode;
        logic       load_valid;
        logic [1:0] load_ch;
        logic [2:0] load_colour;
        logic [11:0] exp_colour;
        logic [3:0] exp_wrap;
        logic       exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [3:0]  button;
    logic [3:0]  dir;
    logic [3:0]  edge_mode;
    logic [3:0]  auto_en;
    logic [11:0] colour;
    logic [3:0]  wrap;

    int checks;
    int errors;

    vec_t vecs[$];

    led_sequencer_if #(.CHANNELS(CHANNELS), .COLOUR_W(COLOUR_W)) load_bus ();

    led_sequencer #(
        .CHANNELS   (CHANNELS),
        .COLOUR_W   (COLOUR_W),
        .MIN_COLOUR (1),
        .MAX_COLOUR (6),
        .PRESCALE   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .dir       (dir),
        .edge_mode (edge_mode),
        .auto_en   (auto_en),
        .load_bus  (load_bus.slave),
        .colour    (colour),
        .wrap      (wrap)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [11:0] pk(input int c3, input int c2, input int c1, input int c0);
        logic [2:0] a, b, c, d;
        a = 3'(c3);
        b = 3'(c2);
        c = 3'(c1);
        d = 3'(c0);
        return {a, b, c, d};
    endfunction

    task automatic add_vec(input string name, input logic [3:0] btn, input logic lv,
                           input logic [1:0] lch, input logic [2:0] lcol,
                           input logic [11:0] ecol, input logic [3:0] ewrap, input logic eerr);
        vec_t v;
        v.name        = name;
        v.button      = btn;
        v.dir         = 4'b0100;
        v.edge_mode   = 4'b0010;
        v.load_valid  = lv;
        v.load_ch     = lch;
        v.load_colour = lcol;
        v.exp_colour  = ecol;
        v.exp_wrap    = ewrap;
        v.exp_err     = eerr;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the falling edge, then let the rising
    // edge register them and settle before checking.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        button               = v.button;
        dir                  = v.dir;
        edge_mode            = v.edge_mode;
        load_bus.load_valid  = v.load_valid;
        load_bus.load_ch     = v.load_ch;
        load_bus.load_colour = v.load_colour;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] ecol,
                               input logic [3:0] ewrap, input logic eerr);
        checks++;
        if (colour !== ecol) begin
            errors++;
            $display("[TB] FAIL %s colour: got %h expected %h", name, colour, ecol);
        end
        checks++;
        if (wrap !== ewrap) begin
            errors++;
            $display("[TB] FAIL %s wrap: got %b expected %b", name, wrap, ewrap);
        end
        checks++;
        if (load_bus.load_err !== eerr) begin
            errors++;
            $display("[TB] FAIL %s load_err: got %b expected %b", name, load_bus.load_err, eerr);
        end
    endtask

    task automatic idle_inputs();
        button               = 4'b0000;
        dir                  = 4'b0100;
        edge_mode            = 4'b0010;
        auto_en              = 4'b0000;
        load_bus.load_valid  = 1'b0;
        load_bus.load_ch     = 2'd0;
        load_bus.load_colour = 3'd0;
    endtask

    // Assert reset away from a clock edge, check it acts without a clock,
    // then release it on a falling edge.
    task automatic pulse_reset(input string name);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput(name, pk(1, 1, 1, 1), 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        vec_t v;
        int   exp_c0;

        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle_inputs();

        // Stepping, wrapping, edge mode, down direction and loads.
        add_vec("up1",     4'b0001, 0, 0, 0, pk(1,1,1,2), 4'b0000, 0);
        add_vec("up2",     4'b0001, 0, 0, 0, pk(1,1,1,3), 4'b0000, 0);
        add_vec("up3",     4'b0001, 0, 0, 0, pk(1,1,1,4), 4'b0000, 0);
        add_vec("up4",     4'b0001, 0, 0, 0, pk(1,1,1,5), 4'b0000, 0);
        add_vec("up5",     4'b0001, 0, 0, 0, pk(1,1,1,6), 4'b0000, 0);
        add_vec("upwrap",  4'b0001, 0, 0, 0, pk(1,1,1,1), 4'b0001, 0);
        add_vec("up7",     4'b0001, 0, 0, 0, pk(1,1,1,2), 4'b0000, 0);
        add_vec("edge1",   4'b0010, 0, 0, 0, pk(1,1,2,2), 4'b0000, 0);
        add_vec("hold1",   4'b0010, 0, 0, 0, pk(1,1,2,2), 4'b0000, 0);
        add_vec("hold2",   4'b0010, 0, 0, 0, pk(1,1,2,2), 4'b0000, 0);
        add_vec("hold3",   4'b0010, 0, 0, 0, pk(1,1,2,2), 4'b0000, 0);
        add_vec("hold4",   4'b0010, 0, 0, 0, pk(1,1,2,2), 4'b0000, 0);
        add_vec("low1",    4'b0000, 0, 0, 0, pk(1,1,2,2), 4'b0000, 0);
        add_vec("pulse1",  4'b0010, 0, 0, 0, pk(1,1,3,2), 4'b0000, 0);
        add_vec("low2",    4'b0000, 0, 0, 0, pk(1,1,3,2), 4'b0000, 0);
        add_vec("pulse2",  4'b0010, 0, 0, 0, pk(1,1,4,2), 4'b0000, 0);
        add_vec("low3",    4'b0000, 0, 0, 0, pk(1,1,4,2), 4'b0000, 0);
        add_vec("pulse3",  4'b0010, 0, 0, 0, pk(1,1,5,2), 4'b0000, 0);
        add_vec("dnwrap",  4'b0100, 0, 0, 0, pk(1,6,5,2), 4'b0100, 0);
        add_vec("dn2",     4'b0100, 0, 0, 0, pk(1,5,5,2), 4'b0000, 0);
        add_vec("ldstep",  4'b1000, 1, 3, 4, pk(4,5,5,2), 4'b0000, 0);
        add_vec("ldlow",   4'b0000, 1, 3, 0, pk(4,5,5,2), 4'b0000, 1);
        add_vec("ldhigh",  4'b0000, 1, 3, 7, pk(4,5,5,2), 4'b0000, 1);
        add_vec("errgone", 4'b0000, 0, 0, 0, pk(4,5,5,2), 4'b0000, 0);
        add_vec("ldother", 4'b1001, 1, 3, 6, pk(6,5,5,3), 4'b0000, 0);
        add_vec("ldmin",   4'b0001, 1, 0, 1, pk(6,5,5,1), 4'b0000, 0);
        add_vec("afterld", 4'b0001, 0, 0, 0, pk(6,5,5,2), 4'b0000, 0);
        add_vec("lddown",  4'b0100, 1, 2, 6, pk(6,6,5,2), 4'b0000, 0);
        add_vec("ch3wrap", 4'b1000, 0, 0, 0, pk(1,6,5,2), 4'b1000, 0);

        // Reset with no clock, release, and three idle cycles.
        #12;
        checkOutput("reset_async", pk(1, 1, 1, 1), 4'b0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_idle", pk(1, 1, 1, 1), 4'b0000, 1'b0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i].name, vecs[i].exp_colour, vecs[i].exp_wrap, vecs[i].exp_err);
        end

        // Mid-run reset with button[1] held high in edge mode: the first edge
        // after release sees an empty history and steps once.
        idle_inputs();
        button = 4'b0010;
        pulse_reset("reset_midrun");
        @(posedge clk);
        #1;
        checkOutput("reset_hist", pk(1, 1, 2, 1), 4'b0000, 1'b0);

        // Level step on ch0, then switch ch0 to edge mode with the button
        // still high: no further step.
        v = '{name: "lvl_then_edge", button: 4'b0011, dir: 4'b0100, edge_mode: 4'b0010,
              load_valid: 1'b0, load_ch: 2'd0, load_colour: 3'd0,
              exp_colour: pk(1, 1, 2, 2), exp_wrap: 4'b0000, exp_err: 1'b0};
        applyStimulus(v);
        checkOutput(v.name, v.exp_colour, v.exp_wrap, v.exp_err);
        v.name      = "edge_switch";
        v.edge_mode = 4'b0011;
        applyStimulus(v);
        checkOutput(v.name, v.exp_colour, v.exp_wrap, v.exp_err);

        // Auto-advance on ch0 from a fresh reset with no buttons.
        idle_inputs();
        pulse_reset("reset_auto");
        auto_en = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
`ifdef AUTO_ADVANCE_EN
            exp_c0 = 1 + k / 4;
`else
            exp_c0 = 1;
`endif
            checkOutput($sformatf("auto_%0d", k), pk(1, 1, 1, exp_c0), 4'b0000, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
